// File: rtl/s9_edge_cnt_if.sv
// ----------------------------------------------------------------------------
// Module   : s9_edge_cnt_if
// Brief    : Level input, control and count/snapshot outputs of s9_edge_cnt.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

interface s9_edge_cnt_if #(
    parameter int CNT_W = 8
);
    logic             din;
    logic             clr;
    logic             rd_req;
    logic             filt;
    logic             rise;
    logic             fall;
    logic [CNT_W-1:0] rise_cnt;
    logic [CNT_W-1:0] fall_cnt;
    logic             ovf;
    logic             snap_vld;
    logic [CNT_W-1:0] snap_rise;
    logic [CNT_W-1:0] snap_fall;

    modport master (
        output din, clr, rd_req,
        input  filt, rise, fall, rise_cnt, fall_cnt, ovf,
        input  snap_vld, snap_rise, snap_fall
    );

    modport slave (
        input  din, clr, rd_req,
        output filt, rise, fall, rise_cnt, fall_cnt, ovf,
        output snap_vld, snap_rise, snap_fall
    );
endinterface

`default_nettype wire

// File: rtl/s9_edge_cnt.sv
// ----------------------------------------------------------------------------
// Module   : s9_edge_cnt
// Brief    : Debounces a level, pulses on edges, counts edges with saturation
//            and offers a coherent snapshot of both counts.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module s9_edge_cnt #(
    parameter int STABLE_CYC = 2,
    parameter int CNT_W      = 8
) (
    input  wire logic         clk,
    input  wire logic         rst,
    s9_edge_cnt_if.slave      bus
);
    localparam int            c_SW       = $clog2(STABLE_CYC + 1);
    localparam logic [c_SW-1:0] c_STAB_MAX = c_SW'(STABLE_CYC);
    localparam logic [c_SW-1:0] c_STAB_ONE = c_SW'(1);

    typedef enum logic [1:0] {
        ST_LO     = 2'd0,
        ST_CHK_HI = 2'd1,
        ST_HI     = 2'd2,
        ST_CHK_LO = 2'd3
    } state_t;

    state_t           r_state;
    logic [c_SW-1:0]  r_stab;
    logic             r_din;
    logic             r_filt;
    logic             r_rise;
    logic             r_fall;
    logic [CNT_W-1:0] r_rise_cnt;
    logic [CNT_W-1:0] r_fall_cnt;
    logic             r_ovf;
    logic             r_snap_vld;
    logic [CNT_W-1:0] r_snap_rise;
    logic [CNT_W-1:0] r_snap_fall;
    logic             w_rise_evt;
    logic             w_fall_evt;

    // Edge events are the qualifying transitions out of the check states.
    always_comb begin
        w_rise_evt = (r_state == ST_CHK_HI) &&  r_din && (r_stab == c_STAB_MAX);
        w_fall_evt = (r_state == ST_CHK_LO) && !r_din && (r_stab == c_STAB_MAX);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= ST_LO;
            r_stab      <= '0;
            r_din       <= 1'b0;
            r_filt      <= 1'b0;
            r_rise      <= 1'b0;
            r_fall      <= 1'b0;
            r_rise_cnt  <= '0;
            r_fall_cnt  <= '0;
            r_ovf       <= 1'b0;
            r_snap_vld  <= 1'b0;
            r_snap_rise <= '0;
            r_snap_fall <= '0;
        end else begin
            r_din  <= bus.din;
            r_rise <= 1'b0;
            r_fall <= 1'b0;

            case (r_state)
                ST_LO: begin
                    if (r_din) begin
                        r_state <= ST_CHK_HI;
                        r_stab  <= c_STAB_ONE;
                    end
                end
                ST_CHK_HI: begin
                    if (!r_din) begin
                        r_state <= ST_LO;
                        r_stab  <= '0;
                    end else if (r_stab == c_STAB_MAX) begin
                        r_state <= ST_HI;
                        r_filt  <= 1'b1;
                        r_rise  <= 1'b1;
                        r_stab  <= '0;
                    end else begin
                        r_stab  <= r_stab + c_STAB_ONE;
                    end
                end
                ST_HI: begin
                    if (!r_din) begin
                        r_state <= ST_CHK_LO;
                        r_stab  <= c_STAB_ONE;
                    end
                end
                ST_CHK_LO: begin
                    if (r_din) begin
                        r_state <= ST_HI;
                        r_stab  <= '0;
                    end else if (r_stab == c_STAB_MAX) begin
                        r_state <= ST_LO;
                        r_filt  <= 1'b0;
                        r_fall  <= 1'b1;
                        r_stab  <= '0;
                    end else begin
                        r_stab  <= r_stab + c_STAB_ONE;
                    end
                end
                default: begin
                    r_state <= ST_LO;
                    r_stab  <= '0;
                end
            endcase

            // Clear takes priority over any coincident edge.
            if (bus.clr) begin
                r_rise_cnt <= '0;
                r_fall_cnt <= '0;
                r_ovf      <= 1'b0;
            end else begin
                if (w_rise_evt) begin
                    if (&r_rise_cnt) r_ovf      <= 1'b1;
                    else             r_rise_cnt <= r_rise_cnt + 1'b1;
                end
                if (w_fall_evt) begin
                    if (&r_fall_cnt) r_ovf      <= 1'b1;
                    else             r_fall_cnt <= r_fall_cnt + 1'b1;
                end
            end

            r_snap_vld <= bus.rd_req;
            if (bus.rd_req) begin
                r_snap_rise <= r_rise_cnt;
                r_snap_fall <= r_fall_cnt;
            end
        end
    end

    assign bus.filt      = r_filt;
    assign bus.rise      = r_rise;
    assign bus.fall      = r_fall;
    assign bus.rise_cnt  = r_rise_cnt;
    assign bus.fall_cnt  = r_fall_cnt;
    assign bus.ovf       = r_ovf;
    assign bus.snap_vld  = r_snap_vld;
    assign bus.snap_rise = r_snap_rise;
    assign bus.snap_fall = r_snap_fall;
endmodule

`default_nettype wire

// File: tb/tb_s9_edge_cnt.sv
// ----------------------------------------------------------------------------
// Module   : tb_s9_edge_cnt
// Brief    : Directed self-checking bench for s9_edge_cnt (CNT_W=4).
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module tb_s9_edge_cnt;
    localparam int W     = 4;
    localparam int c_MAX = (1 << W) - 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    s9_edge_cnt_if #(.CNT_W(W)) bus ();

    s9_edge_cnt #(.STABLE_CYC(2), .CNT_W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    string       q_tag[$];
    logic [31:0] q_exp[$];
    int          exp_r = 0;
    int          exp_f = 0;
    logic        exp_ovf = 1'b0;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic void push(input string t, input logic [31:0] e);
        q_tag.push_back(t);
        q_exp.push_back(e);
    endfunction

    task automatic pop_cmp(input logic [31:0] obs);
        string       t;
        logic [31:0] e;
        n_cmp++;
        if (q_exp.size() == 0) begin
            n_err++;
            $error("FAIL scoreboard_empty observed=%0d expected=none", obs);
        end else begin
            t = q_tag.pop_front();
            e = q_exp.pop_front();
            assert (obs === e) else begin
                n_err++;
                $error("FAIL %s observed=%0d expected=%0d", t, obs, e);
            end
        end
    endtask

    task automatic chk(input string t, input logic [31:0] obs, input logic [31:0] e);
        push(t, e);
        pop_cmp(obs);
    endtask

    task automatic chk_counts(input string t);
        chk({t, "_rise_cnt"}, 32'(bus.rise_cnt), 32'(exp_r));
        chk({t, "_fall_cnt"}, 32'(bus.fall_cnt), 32'(exp_f));
        chk({t, "_ovf"},      32'(bus.ovf),      32'(exp_ovf));
    endtask

    // Drive a clean level long enough to qualify, then update the model.
    task automatic edge_to(input logic v);
        bus.din = v;
        step(6);
        if (v) begin
            if (exp_r == c_MAX) exp_ovf = 1'b1;
            else                exp_r++;
        end else begin
            if (exp_f == c_MAX) exp_ovf = 1'b1;
            else                exp_f++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic saw;

        // Reset dominates din and rd_req.
        rst = 1'b0; bus.din = 1'b1; bus.clr = 1'b0; bus.rd_req = 1'b1;
        step(3);
        chk("rst_filt",     32'(bus.filt),      0);
        chk("rst_rise",     32'(bus.rise),      0);
        chk("rst_fall",     32'(bus.fall),      0);
        chk("rst_snap_vld", 32'(bus.snap_vld),  0);
        chk("rst_snap_r",   32'(bus.snap_rise), 0);
        chk("rst_snap_f",   32'(bus.snap_fall), 0);
        chk_counts("rst");

        // Basic rise: filt on the 4th edge that sees din high.
        rst = 1'b1; bus.rd_req = 1'b0;
        step(3);
        chk("rise_early_filt", 32'(bus.filt), 0);
        step(1);
        exp_r = 1;
        chk("rise_filt",  32'(bus.filt), 1);
        chk("rise_pulse", 32'(bus.rise), 1);
        chk_counts("rise");
        step(1);
        chk("rise_one_cycle", 32'(bus.rise), 0);

        // Fall-side glitch: two low samples are rejected.
        bus.din = 1'b0;
        saw = 1'b0;
        step(2);
        bus.din = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step(1);
            if (bus.fall || !bus.filt) saw = 1'b1;
        end
        chk("glitch_lo_rejected", 32'(saw), 0);
        chk_counts("glitch_lo");

        edge_to(1'b0);
        chk("fall_filt", 32'(bus.filt), 0);
        chk_counts("fall");

        // Rise-side glitch.
        bus.din = 1'b1;
        saw = 1'b0;
        step(2);
        bus.din = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(1);
            if (bus.rise || bus.filt) saw = 1'b1;
        end
        chk("glitch_hi_rejected", 32'(saw), 0);
        chk_counts("glitch_hi");

        // Build rise=5 / fall=4, then a single snapshot.
        edge_to(1'b1); edge_to(1'b0); edge_to(1'b1); edge_to(1'b0);
        edge_to(1'b1); edge_to(1'b0); edge_to(1'b1);
        chk_counts("pre_snap");
        bus.rd_req = 1'b1;
        step(1);
        bus.rd_req = 1'b0;
        chk("snap_vld",  32'(bus.snap_vld),  1);
        chk("snap_rise", 32'(bus.snap_rise), 5);
        chk("snap_fall", 32'(bus.snap_fall), 4);
        step(1);
        chk("snap_vld_drop",  32'(bus.snap_vld),  0);
        chk("snap_rise_hold", 32'(bus.snap_rise), 5);

        // Held request across a new rise.
        edge_to(1'b0);
        bus.din = 1'b1;
        step(2);
        bus.rd_req = 1'b1;
        step(1);
        chk("held_vld1",  32'(bus.snap_vld),  1);
        step(1);
        chk("held_vld2",  32'(bus.snap_vld),  1);
        chk("held_rise2", 32'(bus.snap_rise), 5);
        step(1);
        bus.rd_req = 1'b0;
        exp_r++;
        chk("held_vld3",  32'(bus.snap_vld),  1);
        chk("held_rise3", 32'(bus.snap_rise), 6);
        chk("held_fall3", 32'(bus.snap_fall), 5);
        step(1);
        chk("held_vld_drop", 32'(bus.snap_vld), 0);
        chk_counts("held");

        // clr coincident with a rising edge.
        edge_to(1'b0);
        bus.din = 1'b1;
        step(3);
        bus.clr = 1'b1;
        step(1);
        bus.clr = 1'b0;
        exp_r = 0; exp_f = 0; exp_ovf = 1'b0;
        chk("clr_col_rise", 32'(bus.rise), 1);
        chk("clr_col_filt", 32'(bus.filt), 1);
        chk_counts("clr_col");

        // Saturation and sticky overflow.
        edge_to(1'b0);
        bus.clr = 1'b1;
        step(1);
        bus.clr = 1'b0;
        exp_r = 0; exp_f = 0; exp_ovf = 1'b0;
        for (int i = 0; i < 15; i++) begin
            edge_to(1'b1);
            edge_to(1'b0);
        end
        chk_counts("sat15");
        edge_to(1'b1);
        chk_counts("sat16_rise");
        edge_to(1'b0);
        chk_counts("sat16_fall");
        bus.clr = 1'b1;
        step(1);
        bus.clr = 1'b0;
        exp_r = 0; exp_f = 0; exp_ovf = 1'b0;
        chk_counts("sat_clr");

        // Mid-operation reset while qualifying a rise.
        edge_to(1'b1); edge_to(1'b0);
        chk_counts("pre_midrst");
        bus.din = 1'b1;
        step(2);
        rst = 1'b0;
        step(1);
        exp_r = 0; exp_f = 0; exp_ovf = 1'b0;
        chk("midrst_filt", 32'(bus.filt), 0);
        chk("midrst_rise", 32'(bus.rise), 0);
        chk_counts("midrst");
        rst = 1'b1;
        step(3);
        chk("midrst_requal_early", 32'(bus.filt), 0);
        step(1);
        exp_r = 1;
        chk("midrst_requal_filt", 32'(bus.filt), 1);
        chk("midrst_requal_rise", 32'(bus.rise), 1);
        chk_counts("midrst_requal");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

`default_nettype wire
